// File: rtl/pll_clk_en_gen.sv
// Multi-channel NCO clock-enable generator, running only once the synchronised PLL lock is qualified.
// Optional macro PLL_CLK_EN_GEN_TOGGLE_OUT_EN adds tog_out, a square wave at half each strobe rate.
module pll_clk_en_gen #(
  parameter int              NUM_CH    = 4,
  parameter int              ACC_W     = 32,
  parameter int              LOCK_HOLD = 1024,
  parameter logic [ACC_W-1:0] INIT_INC = 'h0106_24DD,
  localparam int             CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              locked_in,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic [NUM_CH-1:0] clk_en,
`ifdef PLL_CLK_EN_GEN_TOGGLE_OUT_EN
  output logic [NUM_CH-1:0] tog_out,
`endif
  output logic              locked_q
);

  typedef enum logic [1:0] {UNLOCKED, HOLD, RUN} state_t;

  localparam int              HOLD_W    = $clog2(LOCK_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);

  state_t            state, state_nxt;
  logic              lk_m, lk_s;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [ACC_W-1:0]  acc        [NUM_CH];
  logic [ACC_W-1:0]  acc_sum    [NUM_CH];
  logic [ACC_W-1:0]  shadow_inc [NUM_CH];
  logic [ACC_W-1:0]  active_inc [NUM_CH];
  logic [NUM_CH-1:0] carry;
  logic              run_go, run_start;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      UNLOCKED: begin
        if (lk_s) begin
          state_nxt    = HOLD;
          hold_cnt_nxt = '0;
        end
      end
      HOLD: begin
        if (!lk_s)                     state_nxt    = UNLOCKED;
        else if (hold_cnt == HOLD_LAST) state_nxt    = RUN;
        else                           hold_cnt_nxt = hold_cnt + 1'b1;
      end
      RUN: begin
        if (!lk_s) state_nxt = UNLOCKED;
      end
      default: state_nxt = UNLOCKED;
    endcase
  end

  // Accumulators advance only while RUN persists; the entry edge is the phase-aligned restart.
  assign run_go    = (state == RUN) && lk_s;
  assign run_start = (state == HOLD) && (state_nxt == RUN);

  always_comb begin
    carry = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      {carry[i], acc_sum[i]} = {1'b0, acc[i]} + {1'b0, active_inc[i]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      lk_m     <= 1'b0;
      lk_s     <= 1'b0;
      state    <= UNLOCKED;
      hold_cnt <= '0;
      locked_q <= 1'b0;
      clk_en   <= '0;
    end else begin
      lk_m     <= locked_in;
      lk_s     <= lk_m;
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      locked_q <= (state_nxt == RUN);
      clk_en   <= run_go ? carry : '0;
    end
  end

  // NOTE: the increment arrays are reset because their reset value (INIT_INC) is functional state.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i]        <= '0;
        shadow_inc[i] <= INIT_INC;
        active_inc[i] <= INIT_INC;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (run_start) begin
          acc[i]        <= '0;
          active_inc[i] <= shadow_inc[i];
        end else if (run_go) begin
          acc[i] <= acc_sum[i];
          // Retune only at a carry so a period is never cut short.
          if (carry[i]) active_inc[i] <= shadow_inc[i];
        end
        if (cfg_wr && (int'(cfg_ch) == i)) shadow_inc[i] <= cfg_inc;
      end
    end
  end

`ifdef PLL_CLK_EN_GEN_TOGGLE_OUT_EN
  always_ff @(posedge refclk) begin
    if (!rst_n)      tog_out <= '0;
    else if (run_go) tog_out <= tog_out ^ carry;
    else             tog_out <= '0;
  end
`endif

endmodule

// File: tb/tb_pll_clk_en_gen.sv
// Bench for pll_clk_en_gen: cumulative-phase reference model checked every cycle, plus directed literals.
// Honours PLL_CLK_EN_GEN_TOGGLE_OUT_EN when the design is built with it.
module tb_pll_clk_en_gen;

  localparam int          NUM_CH    = 3;
  localparam int          ACC_W     = 32;
  localparam int          LOCK_HOLD = 16;
  localparam logic [31:0] INIT_INC  = 32'h0106_24DD;

  logic              refclk;
  logic              rst_n;
  logic              locked_in;
  logic              cfg_wr;
  logic [1:0]        cfg_ch;
  logic [31:0]       cfg_inc;
  logic [NUM_CH-1:0] clk_en;
  logic              locked_q;
`ifdef PLL_CLK_EN_GEN_TOGGLE_OUT_EN
  logic [NUM_CH-1:0] tog_out;
`endif

  pll_clk_en_gen #(
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_HOLD(LOCK_HOLD), .INIT_INC(INIT_INC)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .locked_in(locked_in),
    .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc),
    .clk_en(clk_en),
`ifdef PLL_CLK_EN_GEN_TOGGLE_OUT_EN
    .tog_out(tog_out),
`endif
    .locked_q(locked_q)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base     = 0;

  always @(posedge refclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: lock qualifies once the synchronised level has been high for LOCK_HOLD+1
  // consecutive edges; each channel keeps an unwrapped phase total and strobes whenever the
  // number of whole 2^ACC_W turns contained in it goes up.
  logic              m_ls1, m_ls2, m_lks, m_was_run, m_locked;
  int                m_streak;
  logic [NUM_CH-1:0] m_en, m_tog;
  logic [31:0]       m_shadow [NUM_CH];
  logic [31:0]       m_active [NUM_CH];
  longint            m_phase  [NUM_CH];
  longint            m_old;

  always @(posedge refclk) begin
    if (!rst_n) begin
      m_ls1 = 1'b0; m_ls2 = 1'b0; m_streak = 0; m_locked = 1'b0;
      m_en = '0; m_tog = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_shadow[i] = INIT_INC; m_active[i] = INIT_INC; m_phase[i] = 0;
      end
    end else begin
      m_lks     = m_ls2;
      m_ls2     = m_ls1;
      m_ls1     = locked_in;
      m_was_run = m_locked;
      m_streak  = m_lks ? m_streak + 1 : 0;
      m_locked  = (m_streak > LOCK_HOLD);
      for (int i = 0; i < NUM_CH; i++) begin
        if (m_streak == LOCK_HOLD + 1) begin
          m_phase[i] = 0; m_active[i] = m_shadow[i]; m_en[i] = 1'b0; m_tog[i] = 1'b0;
        end else if (m_was_run && m_lks) begin
          m_old      = m_phase[i];
          m_phase[i] = m_phase[i] + longint'({32'b0, m_active[i]});
          if ((m_phase[i] >> ACC_W) != (m_old >> ACC_W)) begin
            m_en[i] = 1'b1; m_tog[i] = ~m_tog[i]; m_active[i] = m_shadow[i];
          end else begin
            m_en[i] = 1'b0;
          end
        end else begin
          m_en[i] = 1'b0; m_tog[i] = 1'b0;
        end
      end
      if (cfg_wr && int'(cfg_ch) < NUM_CH) m_shadow[cfg_ch] = cfg_inc;
    end
  end

  always @(negedge refclk) begin
    if (cyc > 0) begin
`ifdef PLL_CLK_EN_GEN_TOGGLE_OUT_EN
      check("cycle_outputs", 64'({tog_out, clk_en, locked_q}), 64'({m_tog, m_en, m_locked}));
`else
      check("cycle_outputs", 64'({clk_en, locked_q}), 64'({m_en, m_locked}));
`endif
    end
  end

  task automatic cfg_write(input logic [1:0] ch, input logic [31:0] inc);
    cfg_wr = 1'b1; cfg_ch = ch; cfg_inc = inc;
    @(negedge refclk);
    cfg_wr = 1'b0;
  endtask

  // Returns the edge number (relative to base) of the first cycle with locked_q high, or -1.
  task automatic wait_lock_rise(input int bound, output int rel, output logic pre_en);
    rel = -1; pre_en = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge refclk);
      if (locked_q) begin
        rel = cyc - base;
        break;
      end
      if (clk_en != '0) pre_en = 1'b1;
    end
  endtask

  task automatic wait_strobe(input int ch, input int bound, output int at);
    at = -1000;
    for (int k = 0; k < bound; k++) begin
      @(negedge refclk);
      if (clk_en[ch]) begin
        at = cyc;
        break;
      end
    end
  endtask

  int          rise, d, cnt0, cnt2, nonuni, t0, t1, t2, t3, hi, lo;
  logic        pre_en;
  logic [5:0]  pat;
  logic [2:0]  lq_pat;

  initial begin
    rst_n = 1'b0; locked_in = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_inc = '0;
    repeat (3) @(negedge refclk);
    check("reset_clk_en", 64'(clk_en), 64'(0));
    check("reset_locked_q", 64'(locked_q), 64'(0));
    rst_n = 1'b1;
    base  = cyc;

    // Program while unlocked: half rate, quarter rate, and a silent channel.
    cfg_write(2'd0, 32'h8000_0000);
    cfg_write(2'd1, 32'h4000_0000);
    cfg_write(2'd2, 32'h0000_0000);
    while (cyc - base < 9) @(negedge refclk);
    locked_in = 1'b1;  // sampled on edge 10
    wait_lock_rise(100, rise, pre_en);
    check("lock_rise_edge", 64'(rise), 64'(10 + 2 + LOCK_HOLD));
    check("clk_en_before_run", 64'(pre_en), 64'(0));

    // RUN cycle 1 is the aligned restart; ch0 carries on every 2nd accumulation from there.
    pat[0] = clk_en[0];
    for (int k = 1; k < 6; k++) begin
      @(negedge refclk);
      pat[k] = clk_en[0];
    end
    check("half_rate_pattern", 64'(pat), 64'(6'b010100));

    cnt0 = 0; cnt2 = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge refclk);
      if (clk_en[0]) cnt0++;
      if (clk_en[2]) cnt2++;
    end
    check("half_rate_count", 64'(cnt0), 64'(500));
    check("zero_inc_never", 64'(cnt2), 64'(0));

`ifdef PLL_CLK_EN_GEN_TOGGLE_OUT_EN
    for (int k = 0; k < 20 && tog_out[1]; k++) @(negedge refclk);
    for (int k = 0; k < 20 && !tog_out[1]; k++) @(negedge refclk);
    hi = 0; lo = 0;
    while (tog_out[1] && hi < 40) begin hi++; @(negedge refclk); end
    while (!tog_out[1] && lo < 40) begin lo++; @(negedge refclk); end
    check("tog_high_cycles", 64'(hi), 64'(4));
    check("tog_low_cycles", 64'(lo), 64'(4));
`endif

    // Retune ch1 mid-period: the period in flight still ends after 4, then 8 takes over.
    wait_strobe(1, 50, t0);
    @(negedge refclk);
    cfg_write(2'd1, 32'h2000_0000);
    wait_strobe(1, 50, t1);
    wait_strobe(1, 50, t2);
    wait_strobe(1, 50, t3);
    check("retune_interval_0", 64'(t1 - t0), 64'(4));
    check("retune_interval_1", 64'(t2 - t1), 64'(8));
    check("retune_interval_2", 64'(t3 - t2), 64'(8));

    // Back to the default rate everywhere; index 3 is beyond NUM_CH and must be dropped.
    cfg_write(2'd0, INIT_INC);
    cfg_write(2'd1, INIT_INC);
    cfg_write(2'd2, INIT_INC);
    cfg_write(2'd3, 32'hFFFF_FFFF);

    // Lock glitch of 3 cycles; locked_q falls on the 3rd edge, then a full hold is required.
    d = cyc - base + 1;
    locked_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge refclk);
      lq_pat[k] = locked_q;
    end
    check("glitch_locked_q", 64'(lq_pat), 64'(3'b011));
    check("glitch_clk_en", 64'(clk_en), 64'(0));
`ifdef PLL_CLK_EN_GEN_TOGGLE_OUT_EN
    check("glitch_tog_out", 64'(tog_out), 64'(0));
`endif
    locked_in = 1'b1;
    wait_lock_rise(100, rise, pre_en);
    check("relock_rise_edge", 64'(rise), 64'(d + 5 + LOCK_HOLD));
    check("clk_en_during_relock", 64'(pre_en), 64'(0));

    // 20001 accumulations of 0x010624DD cross exactly 80 multiples of 2^32.
    cnt0 = 0; nonuni = 0;
    for (int k = 0; k < 20001; k++) begin
      @(negedge refclk);
      if (clk_en[0]) cnt0++;
      if (clk_en != '0 && clk_en != '1) nonuni++;
    end
    check("fractional_count", 64'(cnt0), 64'(80));
    check("channels_aligned", 64'(nonuni), 64'(0));

    // A programmed shadow must not survive a reset in RUN.
    cfg_write(2'd0, 32'h8000_0000);
    rst_n = 1'b0;
    @(negedge refclk);
    check("midrun_reset_locked_q", 64'(locked_q), 64'(0));
    check("midrun_reset_clk_en", 64'(clk_en), 64'(0));
    rst_n = 1'b1;
    base  = cyc;
    cfg_write(2'd2, 32'hFFFF_FFFF);
    wait_lock_rise(100, rise, pre_en);
    check("post_reset_rise_edge", 64'(rise), 64'(2 + 1 + LOCK_HOLD));

    // All-ones increment misses only the very first accumulation; ch0 is back at INIT_INC.
    cnt0 = 0; cnt2 = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge refclk);
      if (clk_en[0]) cnt0++;
      if (clk_en[2]) cnt2++;
    end
    check("max_inc_count", 64'(cnt2), 64'(49));
    check("shadow_lost_count", 64'(cnt0), 64'(0));

    repeat (5) @(negedge refclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
